// File: rtl/measurement_stream_loader.sv
// Streams NUM_BLOCKS blocks of meas_num ROM measurements, LANES words per beat, over
// valid/ready, then pulses done. The ROM holds a built-in ramp (word i = 0x1000+i).
module measurement_stream_loader #(
   parameter int    DATA_W     = 16,
   parameter int    MAX_MEAS   = 48,
   parameter int    GROUP      = 16,
   parameter int    LANES      = 4,
   parameter int    NUM_BLOCKS = 2,
   parameter string INIT_FILE  = "measurements_h.txt"
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            start,
   input  logic [7:0]                      meas_num,
   input  logic                            abort,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [LANES*DATA_W-1:0]         out_data,
   output logic [$clog2(NUM_BLOCKS):0]     out_block,
   output logic                            out_last,
   output logic                            busy,
   output logic                            done,
   output logic                            cfg_err
);

   localparam int ROM_DEPTH = MAX_MEAS * NUM_BLOCKS;
   localparam int ADDR_W    = $clog2(ROM_DEPTH);
   localparam int BLK_W     = $clog2(NUM_BLOCKS) + 1;

   typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DONE} state_t;

   state_t               state;
   logic [7:0]           meas_q;
   logic [7:0]           beat;
   logic [BLK_W-1:0]     blk;

   logic [DATA_W-1:0]    rom [ROM_DEPTH];

   generate
      for (genvar i = 0; i < ROM_DEPTH; i++) begin : g_word
         assign rom[i] = DATA_W'(32'h1000 + i);
      end
   endgenerate

   logic                 legal;
   logic [7:0]           bpb_q;
   logic                 last_beat;
   logic                 final_beat;
   logic [7:0]           next_beat;
   logic [BLK_W-1:0]     next_blk;
   logic [7:0]           ld_beat;
   logic [BLK_W-1:0]     ld_blk;
   logic [7:0]           ld_bpb;
   logic                 ld_last;
   logic [ADDR_W-1:0]    ld_base;
   logic [LANES*DATA_W-1:0] ld_data;

   assign legal      = (meas_num != 8'd0) && ((meas_num % 8'(GROUP)) == 8'd0) &&
                       (meas_num <= 8'(MAX_MEAS));
   assign bpb_q      = meas_q / 8'(LANES);
   assign last_beat  = (beat == bpb_q - 8'd1);
   assign final_beat = last_beat && (blk == BLK_W'(NUM_BLOCKS - 1));
   assign next_beat  = last_beat ? 8'd0 : beat + 8'd1;
   assign next_blk   = last_beat ? blk + BLK_W'(1) : blk;

   // The beat to load: the first one when starting from IDLE, otherwise the successor.
   always_comb begin
      ld_blk  = next_blk;
      ld_beat = next_beat;
      ld_bpb  = bpb_q;
      if (state == S_IDLE) begin
         ld_blk  = '0;
         ld_beat = '0;
         ld_bpb  = meas_num / 8'(LANES);
      end
   end

   assign ld_last = (ld_beat == ld_bpb - 8'd1);
   assign ld_base = ADDR_W'(ld_blk) * ADDR_W'(MAX_MEAS) + ADDR_W'(ld_beat) * ADDR_W'(LANES);

   generate
      for (genvar k = 0; k < LANES; k++) begin : g_lane
         assign ld_data[k*DATA_W +: DATA_W] = rom[ld_base + ADDR_W'(k)];
      end
   endgenerate

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= S_IDLE;
         meas_q    <= '0;
         beat      <= '0;
         blk       <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_block <= '0;
         out_last  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         cfg_err   <= 1'b0;
      end else begin
         done    <= 1'b0;
         cfg_err <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start && legal) begin
                  meas_q    <= meas_num;
                  blk       <= '0;
                  beat      <= '0;
                  out_valid <= 1'b1;
                  out_data  <= ld_data;
                  out_block <= '0;
                  out_last  <= ld_last;
                  busy      <= 1'b1;
                  state     <= S_STREAM;
               end else if (start) begin
                  cfg_err <= 1'b1;
               end
            end
            S_STREAM: begin
               // Abort wins over a simultaneous accept.
               if (abort) begin
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  state     <= S_IDLE;
               end else if (out_ready) begin
                  if (final_beat) begin
                     out_valid <= 1'b0;
                     busy      <= 1'b0;
                     done      <= 1'b1;
                     state     <= S_DONE;
                  end else begin
                     blk       <= next_blk;
                     beat      <= next_beat;
                     out_data  <= ld_data;
                     out_block <= ld_blk;
                     out_last  <= ld_last;
                  end
               end
            end
            S_DONE: state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
